// File: rtl/mips_pkg.sv
// Shared types for the MIPS fetch stage.
// FSM encoding, next-PC select codes, reset PC.
package mips_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_J   = 2'b10,
    PC_JR  = 2'b11
  } pc_sel_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Instruction-memory read port.
// Fetch unit is master, memory is slave.
interface mips_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/mips_next_pc.sv
// Next fetch address calculation.
// Pure combinational, wraps modulo 2^32.
module mips_next_pc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] ir,
  input  logic [31:0] jr_target,
  input  pc_sel_t     sel,
  output logic [31:0] next_pc
);

  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic        unused_ir;

  assign pc_plus4  = pc + 32'd4;
  assign br_off    = {{14{ir[15]}}, ir[15:0], 2'b00};
  assign unused_ir = ^ir[31:26];

  // select target; jr drops misaligned low bits
  always_comb begin
    next_pc = pc_plus4;
    unique case (sel)
      PC_SEQ: next_pc = pc_plus4;
      PC_BR:  next_pc = pc_plus4 + br_off;
      PC_J:   next_pc = {pc_plus4[31:28], ir[25:0], 2'b00};
      PC_JR:  next_pc = jr_target & 32'hFFFF_FFFC;
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch stage.
// Owns PC/IR, fetches via req/ack, applies controller's PC decision.
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = RESET_PC_DEF,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  mips_fetch_unit_if.master  imem,
  output logic [31:0]        IR,
  output logic               ir_valid,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  input  logic               pc_ld_en,
  input  logic [1:0]         pc_next_sel,
  input  logic [31:0]        jr_target,
  input  logic               exec_stall,
  output logic               halted,
  output logic               fetch_err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_n;
  logic [31:0] pc_q, pc_n;
  logic [31:0] ir_q, ir_n;
  logic [7:0]  cnt, cnt_n;
  logic [31:0] next_pc;

  mips_next_pc u_next_pc (
    .pc        (pc_q),
    .ir        (ir_q),
    .jr_target (jr_target),
    .sel       (pc_sel_t'(pc_next_sel)),
    .next_pc   (next_pc)
  );

  // state, PC, IR and timeout counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc_q  <= RESET_PC;
      ir_q  <= 32'h0;
      cnt   <= 8'h0;
    end else begin
      state <= state_n;
      pc_q  <= pc_n;
      ir_q  <= ir_n;
      cnt   <= cnt_n;
    end
  end

  // next state and register updates
  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    ir_n    = ir_q;
    cnt_n   = cnt;
    unique case (state)
      S_IDLE: state_n = S_FETCH;
      S_FETCH: begin
        if (imem.imem_ack) begin
          ir_n    = imem.imem_rdata;
          cnt_n   = 8'h0;
          state_n = S_EXEC;
        end else if (cnt == CNT_LAST) begin
          state_n = S_ERR;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_EXEC: begin
        if (!exec_stall) begin
          if (pc_ld_en) begin
            pc_n    = next_pc;
            state_n = S_FETCH;
          end else begin
            state_n = S_HALT;
          end
        end
      end
      S_HALT:  state_n = S_HALT;
      S_ERR:   state_n = S_ERR;
      default: state_n = S_IDLE;
    endcase
  end

  assign imem.imem_req  = (state == S_FETCH);
  assign imem.imem_addr = pc_q;
  assign ir_valid       = (state == S_EXEC);
  assign halted         = (state == S_HALT);
  assign fetch_err      = (state == S_ERR);
  assign IR             = ir_q;
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + 32'd4;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit.
// Directed + random fetch/exec sequence against a PC/IR model.
module tb_mips_fetch_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] IR, pc, pc_plus4, jr_target;
  logic        ir_valid, pc_ld_en, exec_stall, halted, fetch_err;
  logic [1:0]  pc_next_sel;

  int checks = 0;
  int errors = 0;
  logic [31:0] mpc, mir;

  always #5 clk = ~clk;

  mips_fetch_unit_if imem_bus ();

  mips_fetch_unit #(
    .RESET_PC       (32'h0),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem_bus),
    .IR          (IR),
    .ir_valid    (ir_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .pc_ld_en    (pc_ld_en),
    .pc_next_sel (pc_next_sel),
    .jr_target   (jr_target),
    .exec_stall  (exec_stall),
    .halted      (halted),
    .fetch_err   (fetch_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [1:0] sel,
      input logic [31:0] p, input logic [31:0] ir, input logic [31:0] jr);
    logic [31:0] imm;
    imm = ir[15] ? (32'hFFFF_0000 | {16'h0, ir[15:0]})
                 : {16'h0, ir[15:0]};
    case (sel)
      2'b00:   return p + 32'd4;
      2'b01:   return p + 32'd4 + imm * 32'd4;
      2'b10:   return ((p + 32'd4) & 32'hF000_0000)
                    | ((ir & 32'h03FF_FFFF) * 32'd4);
      default: return jr & ~32'd3;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    imem_bus.imem_ack = 1'b0;
    imem_bus.imem_rdata = $urandom;
    pc_ld_en = 1'b0;
    pc_next_sel = 2'b00;
    jr_target = 32'h0;
    exec_stall = 1'b0;
    @(negedge clk);
    chk("rst_req", 32'(imem_bus.imem_req), 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", IR, 32'h0);
    chk("rst_flags", {29'h0, ir_valid, halted, fetch_err}, 32'h0);
    rst_n = 1'b1;
    mpc = 32'h0;
    mir = 32'h0;
    #1 chk("idle_req", 32'(imem_bus.imem_req), 32'h0);
    @(negedge clk);
  endtask

  task automatic do_fetch(input logic [31:0] word, input int waits);
    for (int i = 0; i < waits; i++) begin
      chk("wait_req", 32'(imem_bus.imem_req), 32'h1);
      chk("wait_addr", imem_bus.imem_addr, mpc);
      chk("wait_irv", 32'(ir_valid), 32'h0);
      imem_bus.imem_ack = 1'b0;
      imem_bus.imem_rdata = $urandom;
      @(negedge clk);
    end
    chk("req", 32'(imem_bus.imem_req), 32'h1);
    chk("addr", imem_bus.imem_addr, mpc);
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = word;
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    imem_bus.imem_rdata = $urandom;
    mir = word;
    chk("ir_valid", 32'(ir_valid), 32'h1);
    chk("IR", IR, mir);
    chk("pc", pc, mpc);
    chk("pc_plus4", pc_plus4, mpc + 32'd4);
    chk("exec_req", 32'(imem_bus.imem_req), 32'h0);
  endtask

  task automatic do_exec(input logic [1:0] sel, input logic ld,
                         input logic [31:0] jr, input int stalls);
    for (int i = 0; i < stalls; i++) begin
      exec_stall = 1'b1;
      pc_next_sel = 2'($urandom);
      pc_ld_en = 1'($urandom);
      jr_target = $urandom;
      @(negedge clk);
      chk("stall_irv", 32'(ir_valid), 32'h1);
      chk("stall_ir", IR, mir);
      chk("stall_pc", pc, mpc);
      chk("stall_req", 32'(imem_bus.imem_req), 32'h0);
    end
    exec_stall = 1'b0;
    pc_next_sel = sel;
    pc_ld_en = ld;
    jr_target = jr;
    if (ld) mpc = model_next(sel, mpc, mir, jr);
    @(negedge clk);
    pc_next_sel = 2'($urandom);
    pc_ld_en = 1'($urandom);
    jr_target = $urandom;
    chk("next_pc", pc, mpc);
    chk("post_irv", 32'(ir_valid), 32'h0);
    chk("post_halt", 32'(halted), ld ? 32'h0 : 32'h1);
  endtask

  initial begin
    do_reset();

    // three sequential zero-wait fetches
    do_fetch(32'h2001_0001, 0);
    do_exec(PC_SEQ, 1'b1, 32'h0, 0);
    chk("seq_addr1", imem_bus.imem_addr, 32'h4);
    do_fetch(32'h2002_0002, 0);
    do_exec(PC_SEQ, 1'b1, 32'h0, 0);
    chk("seq_addr2", imem_bus.imem_addr, 32'h8);
    do_fetch(32'h2003_0003, 0);

    // branches from 0x40
    do_exec(PC_JR, 1'b1, 32'h40, 0);
    do_fetch(32'h1000_FFFE, 0);
    do_exec(PC_BR, 1'b1, 32'h0, 0);
    chk("br_back", pc, 32'h3C);
    do_fetch(32'h0000_0008, 0);
    do_exec(PC_JR, 1'b1, 32'h40, 0);
    do_fetch(32'h1000_0003, 1);
    do_exec(PC_BR, 1'b1, 32'h0, 0);
    chk("br_fwd", pc, 32'h50);

    // jump and misaligned jr
    do_fetch(32'h0000_0008, 0);
    do_exec(PC_JR, 1'b1, 32'hF000_0010, 0);
    do_fetch(32'h0800_0100, 0);
    do_exec(PC_J, 1'b1, 32'h0, 0);
    chk("jump", pc, 32'hF000_0400);
    do_fetch(32'h03E0_0008, 0);
    do_exec(PC_JR, 1'b1, 32'h1237, 0);
    chk("jr_align", pc, 32'h1234);

    // slow memory and execute stall
    do_fetch(32'hCAFE_0001, 5);
    do_exec(PC_SEQ, 1'b1, 32'h0, 3);

    // random traffic
    for (int n = 0; n < 30; n++) begin
      do_fetch($urandom, int'($urandom_range(0, 3)));
      do_exec(2'($urandom_range(0, 3)), 1'b1, $urandom,
              int'($urandom_range(0, 2)));
    end

    // halt, sticky, acks ignored
    do_fetch($urandom, 0);
    do_exec(2'($urandom), 1'b0, $urandom, 1);
    for (int i = 0; i < 4; i++) begin
      imem_bus.imem_ack = 1'b1;
      imem_bus.imem_rdata = $urandom;
      @(negedge clk);
      chk("halt_hold", 32'(halted), 32'h1);
      chk("halt_req", 32'(imem_bus.imem_req), 32'h0);
      chk("halt_ir", IR, mir);
      chk("halt_pc", pc, mpc);
    end
    imem_bus.imem_ack = 1'b0;

    // fetch timeout
    do_reset();
    for (int i = 0; i < 16; i++) begin
      chk("to_req", 32'(imem_bus.imem_req), 32'h1);
      chk("to_err_lo", 32'(fetch_err), 32'h0);
      @(negedge clk);
    end
    chk("to_err", 32'(fetch_err), 32'h1);
    chk("to_req_off", 32'(imem_bus.imem_req), 32'h0);
    chk("to_irv", 32'(ir_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      imem_bus.imem_ack = 1'b1;
      imem_bus.imem_rdata = $urandom;
      @(negedge clk);
      chk("to_sticky", 32'(fetch_err), 32'h1);
      chk("to_ir", IR, 32'h0);
    end
    imem_bus.imem_ack = 1'b0;

    // reset during fetch with simultaneous ack
    do_reset();
    do_fetch(32'h1111_2222, 0);
    do_exec(PC_SEQ, 1'b1, 32'h0, 0);
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    #1;
    chk("mr_ir", IR, 32'h0);
    chk("mr_pc", pc, 32'h0);
    chk("mr_req", 32'(imem_bus.imem_req), 32'h0);
    @(posedge clk);
    #1;
    chk("mr_ir_edge", IR, 32'h0);
    chk("mr_irv_edge", 32'(ir_valid), 32'h0);
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    rst_n = 1'b1;
    mpc = 32'h0;
    mir = 32'h0;
    @(negedge clk);
    do_fetch(32'h3333_4444, 2);
    chk("restart_pc", pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "bench timeout");
  end

endmodule
